// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and data-memory bus bundle for load_store_unit
//   Core side : req_valid, req_ready, is_store, funct3, addr, wdata, resp_valid, mem_data, misalign_err
//   Memory bus: dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, dmem_gnt, dmem_rvalid, dmem_rdata
//   slave  : view taken by the load/store unit itself
//   master : view taken by the surrounding core and data memory
interface load_store_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              is_store;
   logic [2:0]        funct3;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              resp_valid;
   logic [31:0]       mem_data;
   logic              misalign_err;
   logic              dmem_req;
   logic              dmem_we;
   logic [3:0]        dmem_be;
   logic [ADDR_W-1:0] dmem_addr;
   logic [31:0]       dmem_wdata;
   logic              dmem_gnt;
   logic              dmem_rvalid;
   logic [31:0]       dmem_rdata;
   modport slave (
      input  req_valid, is_store, funct3, addr, wdata, dmem_gnt, dmem_rvalid, dmem_rdata,
      output req_ready, resp_valid, mem_data, misalign_err,
             dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata
   );
   modport master (
      output req_valid, is_store, funct3, addr, wdata, dmem_gnt, dmem_rvalid, dmem_rdata,
      input  req_ready, resp_valid, mem_data, misalign_err,
             dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RISC-V load/store unit driving a req/gnt/rvalid data-memory port
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : load_store_unit_if.slave (core request/response + data-memory bus)
//   Optional macro LSU_MISALIGN_TRAP_EN: misaligned/illegal requests skip memory and
//   report misalign_err; when undefined the address is forced to natural alignment instead.
module load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input logic             clk,
   input logic             rst_n,
   load_store_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
   state_t            state, state_nx;
   logic              st;
   logic [2:0]        f3;
   logic [ADDR_W-1:0] a;
   logic [XLEN-1:0]   wd, mem_q, ld;
   logic              err;
   logic              illegal, half, word, bad, accept, in_req;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   always_comb begin
      // Illegal encodings behave as word accesses when not trapping
      illegal = (bus.funct3[1:0] == 2'b11) || (bus.funct3[2] && (bus.is_store || bus.funct3[1]));
      word    = illegal || (bus.funct3[1:0] == 2'b10);
      half    = !illegal && (bus.funct3[1:0] == 2'b01);
`ifdef LSU_MISALIGN_TRAP_EN
      bad     = illegal || (half && bus.addr[0]) || (word && (bus.addr[1:0] != 2'b00));
`else
      bad     = 1'b0;
`endif
      accept  = (state == IDLE) && bus.req_valid;
      state_nx = (state == IDLE) ? (bus.req_valid ? (bad ? RESP : REQ) : IDLE)
               : (state == REQ)  ? (bus.dmem_gnt ? (st ? RESP : WAIT) : REQ)
               : (state == WAIT) ? (bus.dmem_rvalid ? RESP : WAIT)
               : IDLE;
      lane_b = bus.dmem_rdata[{a[1:0], 3'b000} +: 8];
      lane_h = a[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
      ld = (f3 == 3'b000) ? {{24{lane_b[7]}}, lane_b}
         : (f3 == 3'b100) ? {24'b0, lane_b}
         : (f3 == 3'b001) ? {{16{lane_h[15]}}, lane_h}
         : (f3 == 3'b101) ? {16'b0, lane_h}
         : bus.dmem_rdata;
      in_req = (state == REQ);
      // req_ready also depends on rst_n so it reads 0 throughout reset
      bus.req_ready  = rst_n && (state == IDLE);
      bus.dmem_req   = in_req;
      bus.dmem_we    = in_req && st;
      bus.dmem_be    = !in_req ? 4'b0000
                     : (f3[1:0] == 2'b00) ? 4'b0001 << a[1:0]
                     : (f3[1:0] == 2'b01) ? 4'b0011 << {a[1], 1'b0}
                     : 4'b1111;
      bus.dmem_addr  = in_req ? {a[ADDR_W-1:2], 2'b00} : '0;
      bus.dmem_wdata = !(in_req && st) ? 32'b0
                     : (f3[1:0] == 2'b00) ? {4{wd[7:0]}}
                     : (f3[1:0] == 2'b01) ? {2{wd[15:0]}}
                     : wd;
      bus.resp_valid   = (state == RESP);
      bus.misalign_err = (state == RESP) && err;
      bus.mem_data     = mem_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st    <= 1'b0;
         f3    <= 3'b000;
         a     <= '0;
         wd    <= '0;
         err   <= 1'b0;
         mem_q <= '0;
      end else begin
         if (accept) begin
            st  <= bus.is_store;
            f3  <= illegal ? 3'b010 : bus.funct3;
            wd  <= bus.wdata;
            err <= bad;
`ifdef LSU_MISALIGN_TRAP_EN
            a   <= bus.addr;
`else
            a   <= {bus.addr[ADDR_W-1:2],
                    word ? 2'b00 : half ? {bus.addr[1], 1'b0} : bus.addr[1:0]};
`endif
         end
         if (state == WAIT && bus.dmem_rvalid) mem_q <= ld;
      end
   end
endmodule
